// File: rtl/vend_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vend_ctrl_pkg
// Shared definitions for the vending controller: FSM state encoding, the
// credit width (rupees, 0..15) and the item-index width (4 items).
// -----------------------------------------------------------------------------
package vend_ctrl_pkg;

    localparam int CREDIT_W = 4;
    localparam int ITEM_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

endpackage

// File: rtl/vend_price_lut.sv
// -----------------------------------------------------------------------------
// vend_price_lut
// Maps an item index to its price in rupees.
// Ports:
//   item_i  - item index 0..3
//   price_o - price of that item
// -----------------------------------------------------------------------------
module vend_price_lut
    import vend_ctrl_pkg::*;
#(
    parameter int PRICE0 = 3,
    parameter int PRICE1 = 4,
    parameter int PRICE2 = 5,
    parameter int PRICE3 = 7
) (
    input  logic [ITEM_W-1:0]   item_i,
    output logic [CREDIT_W-1:0] price_o
);

    always_comb begin
        price_o = CREDIT_W'(PRICE0);
        case (item_i)
            2'd0:    price_o = CREDIT_W'(PRICE0);
            2'd1:    price_o = CREDIT_W'(PRICE1);
            2'd2:    price_o = CREDIT_W'(PRICE2);
            default: price_o = CREDIT_W'(PRICE3);
        endcase
    end

endmodule

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl
// Coin-operated vending controller: accepts 1/2-rupee coins up to a credit
// ceiling, latches an item selection, dispenses once credit covers the price,
// then pays change one coin at a time. Cancel or an idle timeout refunds.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   coin1, coin2         - coin-inserted pulses (1 / 2 rupees)
//   sel_valid, sel       - item selection pulse and index
//   cancel               - refund request pulse
//   disp_req, disp_item  - dispense request (level) and item, disp_ack completes
//   chg_req              - eject-one-coin request (level), chg_ack completes
//   coin_rej             - pulse: coin returned unaccepted
//   credit               - current credit
//   busy                 - high while dispensing or paying change
// -----------------------------------------------------------------------------
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 5,
    parameter int PRICE3     = 7,
    parameter int MAX_CREDIT = 9,
    parameter int TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin1,
    input  logic                coin2,
    input  logic                sel_valid,
    input  logic [ITEM_W-1:0]   sel,
    input  logic                cancel,
    output logic                disp_req,
    output logic [ITEM_W-1:0]   disp_item,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                pend_vld_q, pend_vld_d;
    logic [ITEM_W-1:0]   pend_idx_q, pend_idx_d;
    logic [ITEM_W-1:0]   disp_item_q, disp_item_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                coin_rej_q, coin_rej_d;

    logic [ITEM_W-1:0]   lut_idx;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_open;
    logic                coin_ok;
    logic                activity;

    // One LUT serves both uses: the pending item while collecting, the
    // latched item while dispensing (for the credit deduction).
    assign lut_idx = (state_q == ST_DISPENSE) ? disp_item_q : pend_idx_q;

    vend_price_lut #(
        .PRICE0 (PRICE0),
        .PRICE1 (PRICE1),
        .PRICE2 (PRICE2),
        .PRICE3 (PRICE3)
    ) u_price_lut (
        .item_i  (lut_idx),
        .price_o (price)
    );

    // Extra bit so credit + 2 cannot wrap before the ceiling compare.
    assign coin_val   = coin2 ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(1);
    assign coin_open  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign coin_ok    = coin_open && (coin1 ^ coin2) &&
                        (({1'b0, credit_q} + coin_val) <= (CREDIT_W+1)'(MAX_CREDIT));
    assign credit_sum = {1'b0, credit_q} + (coin_ok ? coin_val : '0);
    assign activity   = coin_ok || sel_valid;

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        pend_vld_d  = pend_vld_q;
        pend_idx_d  = pend_idx_q;
        disp_item_d = disp_item_q;
        tmo_d       = '0;
        coin_rej_d  = (coin1 || coin2) && !coin_ok;

        case (state_q)
            ST_IDLE: begin
                credit_d = credit_sum[CREDIT_W-1:0];
                if (coin_ok) begin
                    state_d = ST_COLLECT;
                end
                if (sel_valid) begin
                    pend_vld_d = 1'b1;
                    pend_idx_d = sel;
                end
            end

            ST_COLLECT: begin
                // Coins accepted this cycle are banked even if we leave.
                credit_d = credit_sum[CREDIT_W-1:0];
                if (cancel) begin
                    state_d    = ST_CHANGE;
                    pend_vld_d = 1'b0;
                end else if (!activity && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
                    state_d    = ST_CHANGE;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q && (credit_q >= price)) begin
                    // Uses registered credit; a selection arriving in this
                    // same cycle is dropped along with the consumed one.
                    state_d     = ST_DISPENSE;
                    disp_item_d = pend_idx_q;
                    pend_vld_d  = 1'b0;
                end else begin
                    if (sel_valid) begin
                        pend_vld_d = 1'b1;
                        pend_idx_d = sel;
                    end
                    tmo_d = activity ? '0 : tmo_q + TMO_W'(1);
                end
            end

            ST_DISPENSE: begin
                if (disp_ack) begin
                    credit_d = credit_q - price;
                    state_d  = (credit_q != price) ? ST_CHANGE : ST_IDLE;
                end
            end

            default: begin // ST_CHANGE
                if (chg_ack) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            credit_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            disp_item_q <= '0;
            tmo_q       <= '0;
            coin_rej_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
            disp_item_q <= disp_item_d;
            tmo_q       <= tmo_d;
            coin_rej_q  <= coin_rej_d;
        end
    end

    assign disp_req  = (state_q == ST_DISPENSE);
    assign disp_item = disp_item_q;
    assign chg_req   = (state_q == ST_CHANGE);
    assign busy      = disp_req || chg_req;
    assign coin_rej  = coin_rej_q;
    assign credit    = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

    localparam int TMO   = 20;
    localparam int MAXC  = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin1 = 0, coin2 = 0, sel_valid = 0, cancel = 0;
    logic [1:0] sel = 0;
    logic       disp_ack = 0, chg_ack = 0;
    logic       disp_req, chg_req, coin_rej, busy;
    logic [1:0] disp_item;
    logic [3:0] credit;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    vend_ctrl #(
        .PRICE0(3), .PRICE1(4), .PRICE2(5), .PRICE3(7),
        .MAX_CREDIT(MAXC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .coin1(coin1), .coin2(coin2),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .disp_req(disp_req), .disp_item(disp_item), .disp_ack(disp_ack),
        .chg_req(chg_req), .chg_ack(chg_ack),
        .coin_rej(coin_rej), .credit(credit), .busy(busy)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 collecting, 2 dispensing, 3 paying change
    int price [4] = '{3, 4, 5, 7};
    int m_mode, m_credit, m_item, m_pidx, m_quiet;
    bit m_pend, m_rej;

    task automatic model_reset();
        m_mode = 0; m_credit = 0; m_item = 0; m_pidx = 0;
        m_quiet = 0; m_pend = 0; m_rej = 0;
    endtask

    task automatic model_step();
        int  value;
        int  banked;
        bit  accepting, took;
        value     = coin2 ? 2 : 1;
        accepting = (m_mode <= 1);
        took      = accepting && (coin1 != coin2) && (m_credit + value <= MAXC);
        m_rej     = (coin1 || coin2) && !took;
        banked    = m_credit;
        if (took) m_credit = m_credit + value;
        if (m_mode == 0) begin
            if (took) m_mode = 1;
            if (sel_valid) begin m_pend = 1; m_pidx = sel; end
            m_quiet = 0;
        end else if (m_mode == 1) begin
            if (cancel) begin
                m_mode = 3; m_pend = 0; m_quiet = 0;
            end else if (!(took || sel_valid) && m_quiet + 1 >= TMO) begin
                m_mode = 3; m_pend = 0; m_quiet = 0;
            end else if (m_pend && banked >= price[m_pidx]) begin
                m_mode = 2; m_item = m_pidx; m_pend = 0; m_quiet = 0;
            end else begin
                if (sel_valid) begin m_pend = 1; m_pidx = sel; end
                m_quiet = (took || sel_valid) ? 0 : m_quiet + 1;
            end
        end else if (m_mode == 2) begin
            if (disp_ack) begin
                m_credit = m_credit - price[m_item];
                m_mode = (m_credit > 0) ? 3 : 0;
            end
        end else begin
            if (chg_ack) begin
                m_credit = m_credit - 1;
                if (m_credit == 0) m_mode = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d @%0t", name, act, exp, $time);
    endtask

    task automatic compare_model();
        logic [9:0] exp_v, act_v;
        logic [1:0] mi;
        logic [3:0] mc;
        mi = 2'(m_item);
        mc = 4'(m_credit);
        exp_v = {m_mode == 2, (m_mode == 2) ? mi : 2'b00, m_mode == 3, m_rej,
                 m_mode >= 2, mc};
        act_v = {disp_req, disp_req ? disp_item : 2'b00, chg_req, coin_rej, busy, credit};
        total_cnt++;
        if (act_v == exp_v) pass_cnt++;
        else $display("FAIL model_cmp: got {dreq,item,creq,rej,busy,credit}=%b expected %b @%0t",
                      act_v, exp_v, $time);
    endtask

    // One transaction = one clock cycle of inputs; called at negedge.
    task automatic cyc(input bit c1, input bit c2, input bit sv, input int s,
                       input bit cn, input bit da, input bit ca);
        coin1 = c1; coin2 = c2; sel_valid = sv; sel = 2'(s);
        cancel = cn; disp_ack = da; chg_ack = ca;
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        compare_model();
        coin1 = 0; coin2 = 0; sel_valid = 0; cancel = 0; disp_ack = 0; chg_ack = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    int n_ack;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        idle(1);
        rst = 0;
        idle(1);
        check("reset_credit", credit, 0);
        check("reset_busy", {disp_req, chg_req, coin_rej, busy}, 0);

        // Two 2-rupee coins, select item 0, dispense, one change coin.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("t1_credit4", credit, 4);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("t1_no_disp_yet", disp_req, 0);
        idle(1);
        check("t1_disp_req", disp_req, 1);
        check("t1_disp_item", disp_item, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("t1_credit_after_ack", credit, 1);
        check("t1_chg_req", chg_req, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("t1_idle_credit", credit, 0);
        check("t1_idle_busy", busy, 0);

        // Select item 3 first, then seven 1-rupee coins.
        cyc(0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        check("t2_credit7", credit, 7);
        check("t2_not_yet", disp_req, 0);
        idle(1);
        check("t2_disp_req", disp_req, 1);
        check("t2_disp_item", disp_item, 3);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("t2_no_change", chg_req, 0);
        check("t2_credit0", credit, 0);

        // Ceiling rejection and simultaneous coins at credit 8.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        check("t3_credit8", credit, 8);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("t3_rej_over", coin_rej, 1);
        check("t3_credit_kept", credit, 8);
        idle(1);
        check("t3_rej_pulse_end", coin_rej, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("t3_rej_both", coin_rej, 1);
        check("t3_credit_kept2", credit, 8);
        idle(1);
        check("t3_single_pulse", coin_rej, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        check("t3_drained", credit, 0);

        // Cancel at credit 5: five refunds, coin rejected while refunding.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("t4_chg_req", chg_req, 1);
        check("t4_credit5", credit, 5);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t4_rej_in_change", coin_rej, 1);
        check("t4_credit_still5", credit, 5);
        n_ack = 0;
        for (int i = 0; i < 10 && chg_req; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            n_ack++;
        end
        check("t4_ack_count", n_ack, 5);
        check("t4_idle", busy, 0);

        // Timeout with credit 2.
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(TMO - 1);
        check("t5_before_tmo", chg_req, 0);
        idle(1);
        check("t5_tmo_chg_req", chg_req, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("t5_refunded", {busy, credit}, 0);

        // Asynchronous reset in the middle of a dispense.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        idle(1);
        check("t6_dispensing", disp_req, 1);
        #2 rst = 1;
        #1;
        check("t6_async_outs", {disp_req, disp_item, chg_req, coin_rej, busy}, 0);
        check("t6_async_credit", credit, 0);
        model_reset();
        @(negedge clk);
        idle(1);
        rst = 0;
        idle(2);
        check("t6_after_release", {busy, credit}, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst = 1;
                idle(1);
                rst = 0;
            end
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 40) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE0, default 3, price of item 0 in rupees.
REQ-002 Parameter PRICE1, default 4, price of item 1 in rupees.
REQ-003 Parameter PRICE2, default 5, price of item 2 in rupees.
REQ-004 Parameter PRICE3, default 7, price of item 3 in rupees.
REQ-005 Parameter MAX_CREDIT, default 9, credit ceiling in rupees (legal range 7..15).
REQ-006 Parameter TIMEOUT, default 1000, idle cycles in COLLECT before auto-refund.
REQ-007 clk  input  1  single clock; all state updates on posedge clk.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 coin1  input  1  one-cycle pulse: 1-rupee coin inserted.
REQ-010 coin2  input  1  one-cycle pulse: 2-rupee coin inserted.
REQ-011 sel_valid  input  1  one-cycle pulse: item selection present on sel.
REQ-012 sel  input  2  selected item index 0..3.
REQ-013 cancel  input  1  one-cycle pulse: user requests refund.
REQ-014 disp_req  output  1  dispense request to mechanism, level.
REQ-015 disp_item  output  2  item to dispense, stable while disp_req=1.
REQ-016 disp_ack  input  1  mechanism completion pulse.
REQ-017 chg_req  output  1  request to eject one 1-rupee coin, level.
REQ-018 chg_ack  input  1  coin-ejector completion pulse.
REQ-019 coin_rej  output  1  one-cycle pulse: coin returned unaccepted.
REQ-020 credit  output  4  current accepted credit in rupees.
REQ-021 busy  output  1  high in DISPENSE and CHANGE.

Function
REQ-022 FSM states SHALL be IDLE, COLLECT, DISPENSE, CHANGE.
REQ-023 IDLE/COLLECT: an accepted coin1 adds 1 and an accepted coin2 adds 2 to credit on the next edge; IDLE goes to COLLECT on the first accepted coin.
REQ-024 A coin SHALL be rejected (coin_rej=1 on the next cycle, credit unchanged) if credit+value > MAX_CREDIT, if the FSM is in DISPENSE or CHANGE, or if coin1 and coin2 arrive in the same cycle (both rejected, single coin_rej pulse).
REQ-025 sel_valid SHALL latch sel into a pending-selection register, valid in IDLE and COLLECT only; a later sel_valid overwrites it; sel_valid in DISPENSE/CHANGE is ignored.
REQ-026 From COLLECT, a pending selection with credit >= its price SHALL move to DISPENSE on the next edge, asserting disp_req with disp_item = pending index; the pending selection is then cleared.
REQ-027 disp_req and disp_item SHALL hold until the cycle disp_ack=1; on that edge credit -= price, then CHANGE if the remainder >0, else IDLE.
REQ-028 CHANGE: chg_req=1; each chg_ack decrements credit by 1; when credit reaches 0, chg_req drops on the same edge and the FSM enters IDLE.
REQ-029 cancel in COLLECT SHALL go to CHANGE (full refund), clearing the pending selection; cancel elsewhere is ignored.
REQ-030 Timeout counter SHALL reset on every accepted coin or sel_valid and count each COLLECT cycle; at TIMEOUT it SHALL force CHANGE, same as cancel.
REQ-031 Priority in COLLECT in one cycle: cancel > timeout > dispense check; a coin accepted in the same cycle is still added before the refund starts.
REQ-032 Dispense check SHALL use the registered credit (coins arriving in the same cycle count from the following cycle), giving a 1-cycle latency from the sufficient-credit state to disp_req.
REQ-033 Acks not matching the current request (disp_ack outside DISPENSE, chg_ack outside CHANGE) SHALL be ignored.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, credit=0, pending selection cleared, timeout counter=0, and disp_req, disp_item, chg_req, coin_rej, busy all 0, including mid-dispense or mid-change.

Structure
REQ-035 A shared package SHALL hold the state enum, the credit width (4), and the item-index width (2).
REQ-036 One sub-module, vend_price_lut (item index to price, from the PRICE parameters), SHALL be instantiated; the rest stays in vend_ctrl.

Verification
REQ-037 coin2,coin2 then sel_valid sel=0 -> disp_req with disp_item=0; after disp_ack, credit=1, one chg_req/chg_ack cycle, then IDLE with credit=0.
REQ-038 sel_valid sel=3 at credit 0, then seven coin1 -> disp_req asserts 1 cycle after credit=7; after disp_ack, IDLE with no chg_req.
REQ-039 credit=8, coin2 -> coin_rej pulse, credit stays 8; coin1 and coin2 in the same cycle -> one coin_rej, credit unchanged.
REQ-040 credit=5, cancel -> CHANGE, exactly five chg_ack handshakes, then IDLE; coin1 during CHANGE -> coin_rej.
REQ-041 credit=2, no activity for TIMEOUT cycles -> chg_req, two refunds; rst asserted mid-DISPENSE -> all outputs 0 asynchronously, IDLE after release.
